// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer: FSM state, mode priority
// decode, and lamp-index mapping from (side, position) to the out[] bit.
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } tl_state_t;

  // Hazard wins, and so does a simultaneous left+right request.
  function automatic tl_state_t decode_mode(input logic hazard_in,
                                            input logic left_in,
                                            input logic right_in);
    if (hazard_in || (left_in && right_in)) return HAZ;
    else if (left_in)                       return LEFT;
    else if (right_in)                      return RIGHT;
    return IDLE;
  endfunction

  // Position 0 is the innermost lamp on either side.
  function automatic int left_idx(input int lamps, input int pos);
    return lamps + pos;
  endfunction

  function automatic int right_idx(input int lamps, input int pos);
    return lamps - 1 - pos;
  endfunction

endpackage

// File: rtl/tail_step_timer.sv
// Step prescaler: counts 0..STEP_DIV-1 and flags tick on the last count.
// A clear restarts the step so a new mode always begins with a full step.
module tail_step_timer #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(STEP_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(STEP_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tail_light_seq.sv
// Parametrised tail-light sequencer: turn sequencing, hazard flash, brake and dimmed
// run lights. Define TAIL_FULL_CYCLE_EN to let a running turn sequence finish first.
module tail_light_seq #(
  parameter int LAMPS_PER_SIDE = 3,
  parameter int STEP_DIV       = 16,
  parameter int PWM_BITS       = 3,
  parameter int RUN_DUTY       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        left,
  input  logic                        right,
  input  logic                        brake,
  input  logic                        hazard,
  input  logic                        run,
  output logic [2*LAMPS_PER_SIDE-1:0] out
);

  import tail_light_pkg::*;

  localparam int L     = LAMPS_PER_SIDE;
  localparam int SEQ_W = $clog2(L + 1);

  tl_state_t           state_q, state_d, mode;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                haz_on_q, haz_on_d;
  logic                brake_q, run_q;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [2*L-1:0]      out_q, out_d;
  logic [L-1:0]        lit_l, lit_r;
  logic                tick, take, seq_wrap, dim;

  assign mode     = decode_mode(hazard, left, right);
  assign seq_wrap = tick && (seq_q == SEQ_W'(L));

`ifdef TAIL_FULL_CYCLE_EN
  // A turn sequence only yields to a non-hazard mode at its wrap tick.
  assign take = (mode != state_q) &&
                ((mode == HAZ) || !((state_q == LEFT) || (state_q == RIGHT)) || seq_wrap);
`else
  assign take = (mode != state_q);
`endif

  tail_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (take),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    haz_on_d = haz_on_q;
    if (take) begin
      state_d  = mode;
      seq_d    = ((mode == LEFT) || (mode == RIGHT)) ? SEQ_W'(1) : '0;
      haz_on_d = (mode == HAZ);
    end else if (tick) begin
      case (state_q)
        LEFT, RIGHT: seq_d    = seq_wrap ? '0 : seq_q + SEQ_W'(1);
        HAZ:         haz_on_d = !haz_on_q;
        default:     ;
      endcase
    end
  end

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
  assign dim       = ({1'b0, pwm_cnt_q} < (PWM_BITS + 1)'(RUN_DUTY));

  // Priority per lamp: sequence/hazard, then brake (non-sequencing side), then dim.
  always_comb begin
    lit_l = '0;
    lit_r = '0;
    for (int i = 0; i < L; i++) begin
      if (state_q == HAZ) begin
        lit_l[i] = haz_on_q || (run_q && dim);
        lit_r[i] = haz_on_q || (run_q && dim);
      end else begin
        lit_l[i] = ((state_q == LEFT) && (seq_q > SEQ_W'(i))) ||
                   (brake_q && (state_q != LEFT)) || (run_q && dim);
        lit_r[i] = ((state_q == RIGHT) && (seq_q > SEQ_W'(i))) ||
                   (brake_q && (state_q != RIGHT)) || (run_q && dim);
      end
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lamp_map
    assign out_d[left_idx(L, g)]  = lit_l[g];
    assign out_d[right_idx(L, g)] = lit_r[g];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      haz_on_q  <= 1'b0;
      brake_q   <= 1'b0;
      run_q     <= 1'b0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      haz_on_q  <= haz_on_d;
      brake_q   <= brake;
      run_q     <= run;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq (L=3, STEP_DIV=4, PWM_BITS=2, RUN_DUTY=1).
// Expected lamp patterns are queued per cycle and checked by a negedge monitor.
module tb_tail_light_seq;

  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         left = 1'b1, right = 1'b1, brake = 1'b1, hazard = 1'b1, run = 1'b1;
  logic [2*L-1:0] out;

  logic [2*L-1:0] exp_q[$];
  string          name_q[$];
  logic [2*L-1:0] exp_v;
  string          name_v;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  tail_light_seq #(
    .LAMPS_PER_SIDE (L),
    .STEP_DIV       (4),
    .PWM_BITS       (2),
    .RUN_DUTY       (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .left   (left),
    .right  (right),
    .brake  (brake),
    .hazard (hazard),
    .run    (run),
    .out    (out)
  );

  // Monitor: everything queued since the last posedge is due now.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_v  = exp_q.pop_front();
      name_v = name_q.pop_front();
      checks++;
      if (out !== exp_v) begin
        errors++;
        $display("FAIL %s: out=%b expected=%b", name_v, out, exp_v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [2*L-1:0] e);
    step();
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic chk_n(input string n, input int cnt, input logic [2*L-1:0] e);
    for (int k = 0; k < cnt; k++) chk(n, e);
  endtask

  task automatic set_in(input logic l, input logic r, input logic b,
                        input logic h, input logic rn);
    left = l; right = r; brake = b; hazard = h; run = rn;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    chk("rst_mid", 6'b000000);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1);
  end

  initial begin
    // Reset held with every input asserted.
    chk_n("rst_hold", 3, 6'b000000);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    chk_n("rst_release", 4, 6'b000000);

    // Left turn sequence through a full wrap.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    chk("left_e", 6'b000000);
    chk_n("left_p1", 4, 6'b001000);
    chk_n("left_p2", 4, 6'b011000);
    chk_n("left_p3", 4, 6'b111000);
    chk_n("left_p0", 4, 6'b000000);
    chk_n("left_p1b", 4, 6'b001000);

    // Right turn with brake: left side solid, right side sequences.
    do_reset();
    set_in(0, 1, 1, 0, 0);
    chk("rbrk_e", 6'b000000);
    chk_n("rbrk_p1", 4, 6'b111100);
    chk_n("rbrk_p2", 4, 6'b111110);
    chk_n("rbrk_p3", 4, 6'b111111);
    chk_n("rbrk_p0", 4, 6'b111000);
    chk_n("rbrk_p1b", 4, 6'b111100);

    // Left+right+brake decodes to hazard; brake is overridden.
    do_reset();
    set_in(1, 1, 1, 0, 0);
    chk("lrb_e", 6'b000000);
    chk_n("lrb_on", 4, 6'b111111);
    chk_n("lrb_off", 4, 6'b000000);
    chk_n("lrb_on2", 4, 6'b111111);

    // Hazard switch alone.
    do_reset();
    set_in(0, 0, 0, 1, 0);
    chk("haz_e", 6'b000000);
    chk_n("haz_on", 4, 6'b111111);
    chk_n("haz_off", 4, 6'b000000);
    chk_n("haz_on2", 4, 6'b111111);

    // Brake only.
    do_reset();
    set_in(0, 0, 1, 0, 0);
    chk("brk_e", 6'b000000);
    chk_n("brk_on", 4, 6'b111111);

    // Run lights dimmed to 1 of 4 cycles.
    do_reset();
    set_in(0, 0, 0, 0, 1);
    chk("run_e", 6'b000000);
    for (int p = 0; p < 2; p++) begin
      chk_n("run_off", 3, 6'b000000);
      chk("run_on", 6'b111111);
    end

    // Run with left: lit turn lamps stay solid, others dim.
    do_reset();
    set_in(1, 0, 0, 0, 1);
    chk("runl_e", 6'b000000);
    chk_n("runl_p1", 3, 6'b001000);
    chk("runl_dim1", 6'b111111);
    chk_n("runl_p2", 3, 6'b011000);
    chk("runl_dim2", 6'b111111);

    // Drop left at phase 2.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    chk("drop_e", 6'b000000);
    chk_n("drop_p1", 4, 6'b001000);
    chk("drop_p2", 6'b011000);
    set_in(0, 0, 0, 0, 0);
    chk("drop_edge", 6'b011000);
`ifdef TAIL_FULL_CYCLE_EN
    chk_n("drop_hold_p2", 2, 6'b011000);
    chk_n("drop_hold_p3", 4, 6'b111000);
    chk_n("drop_idle", 3, 6'b000000);
`else
    chk_n("drop_idle", 4, 6'b000000);
`endif

    // Hazard mid-sequence is immediate in both builds.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    chk("hmid_e", 6'b000000);
    chk_n("hmid_p1", 4, 6'b001000);
    chk("hmid_p2", 6'b011000);
    set_in(1, 0, 0, 1, 0);
    chk("hmid_edge", 6'b011000);
    chk_n("hmid_on", 4, 6'b111111);
    chk("hmid_off", 6'b000000);

    do_reset();
    step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised successor to the fixed six-lamp Thunderbird tail-light controller.
- Drives LAMPS_PER_SIDE lamps per side.
- Generates its own step timing and run-light PWM from one clock, so no separate dim clock is needed.
- Sits between the driver-input debounce logic and the lamp driver outputs.

Parameters:
- LAMPS_PER_SIDE, 3, lamps per side (L); legal range 2..8.
- STEP_DIV, 16, clk cycles per sequence step; must be >= 2.
- PWM_BITS, 3, width of the free-running run-light PWM counter.
- RUN_DUTY, 2, run-light on-count per PWM period (RUN_DUTY / 2^PWM_BITS); 0 disables dimming.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous active-low reset.
- left  in  1  left turn request.
- right  in  1  right turn request.
- brake  in  1  brake pedal.
- hazard  in  1  hazard switch.
- run  in  1  running lights enable.
- out  out  2*L  lamp drives. Left lamp i (0 = innermost) is out[L+i]; right lamp i is out[L-1-i].

Behaviour:
- Reset (rst=0 at a clk edge): out=0, state=IDLE, seq=0, haz_on=0, prescaler=0, pwm_cnt=0.
- Mode decode, evaluated every cycle, in priority order:
  - hazard OR (left AND right) -> HAZ
  - left -> LEFT
  - right -> RIGHT
  - otherwise IDLE
- Brake never changes state; it only affects output composition.
- FSM states: IDLE, LEFT, RIGHT, HAZ.
- On any state change, the prescaler clears to 0. Entering LEFT or RIGHT sets seq=1. Entering HAZ sets haz_on=1.
- Tick: asserted when prescaler == STEP_DIV-1; the prescaler then wraps to 0.
- LEFT/RIGHT on tick: seq advances 1, 2, ..., L, 0, 1, ... (L+1 phases). At phase k the k innermost lamps of the active side are lit.
- HAZ on tick: haz_on toggles. All 2L lamps follow haz_on.
- Output composition, per lamp:
  - A lamp lit by the sequence or hazard is fully on.
  - In HAZ, hazard overrides brake; off-phase lamps are dark, or dim if run=1.
  - Otherwise with brake=1, every lamp of a side that is not sequencing is fully on. The sequencing side shows its sequence only.
  - Any lamp still off is driven by the dim bit when run=1. dim = (pwm_cnt < RUN_DUTY).
- pwm_cnt is free-running, wraps at 2^PWM_BITS, and is unaffected by mode changes.
- Latency: an input sampled at edge E sets state/seq at E; out reflects it after edge E+1. out is registered, so there is no combinational path from input to out.
- Reset mid-sequence takes effect at the next edge: everything returns to reset values, and out=0 one cycle later.
- Releasing turn inputs drops to IDLE immediately; the sequence is aborted.
- Widths: seq is clog2(L+1) bits and the prescaler is clog2(STEP_DIV) bits; neither may overflow.

Optional Feature:
- Macro: TAIL_FULL_CYCLE_EN.
- Defined:
  - A pending transition out of LEFT or RIGHT to IDLE, LEFT or RIGHT is deferred until seq wraps to 0 on a tick; the new mode is entered on that tick.
  - Transitions into HAZ and reset remain immediate.
  - A transition to brake-only waits for the cycle to complete, while brake lamps still light immediately via output composition.
- Undefined: all transitions are immediate, as described in Behaviour.

Decomposition:
- tail_light_pkg holds:
  - state enum tl_state_t {IDLE, LEFT, RIGHT, HAZ}
  - mode-priority decode function
  - lamp-index helper functions (left_idx, right_idx)
- Sub-module tail_step_timer: prescaler plus tick generation, with a clear input. Parameter STEP_DIV.
- The PWM counter stays in the top level.

Test Plan:
All scenarios use L=3, STEP_DIV=4, PWM_BITS=2, RUN_DUTY=1.
- Reset: rst=0 for 3 cycles with all inputs=1 -> out=000000 one cycle after the first reset edge. After release with inputs 0, out stays 000000.
- Left turn: left=1 sampled at E -> out 001000 at E+1, 011000 at E+5, 111000 at E+9, 000000 at E+13, 001000 at E+17.
- Right with brake: right=1, brake=1 -> out 111100, then 111110, 111111, 111000, repeating every 4 cycles.
- Left+right with brake: left=right=brake=1 -> HAZ; out alternates 111111 and 000000 every 4 cycles. hazard=1 alone gives an identical pattern.
- Run dim: run=1, all else 0 -> out=111111 for 1 of every 4 cycles, 000000 for the other 3. With left=1 added, the lit left lamps stay at 1 every cycle.
- TAIL_FULL_CYCLE_EN: left=1, drop left at phase 2 -> out continues 111000 then 000000 before IDLE. Without the macro -> out=000000 one cycle after the drop. Asserting hazard mid-sequence switches to 111111 next cycle in both builds.
